// File: rtl/request_unit_pkg.sv
// Shared types for the data-memory request path: request opcode, the default
// request record and a decode helper for the datapath enables.
package request_unit_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_op_t;

    typedef struct packed {
        req_op_t             op;
        logic [ADDR_W-1:0]   addr;
        logic [WORD_W-1:0]   data;
    } req_t;

    // A write enable always wins: a request with both enables set is a write.
    function automatic req_op_t req_op_decode(input logic wen);
        return wen ? REQ_WRITE : REQ_READ;
    endfunction

endpackage

// File: rtl/request_queue_if.sv
// Datapath/memory-side bundle of the request queue.
// Handshake: the datapath offers a request on ihit with dREN/dWEN and must
// hold while stall is high; the memory side retires the head by pulsing dhit
// for one cycle while dMemREN or dMemWEN is high.
interface request_queue_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             ihit;
    logic             dREN;
    logic             dWEN;
    logic [AW-1:0]    daddr;
    logic [DW-1:0]    dstore;
    logic             dhit;
    logic             halt;

    logic             dMemREN;
    logic             dMemWEN;
    logic [AW-1:0]    dMemAddr;
    logic [DW-1:0]    dMemStore;
    logic             stall;
    logic [CNT_W-1:0] pending;
    logic             timeout;
    logic             drained;

    modport rq (
        input  ihit, dREN, dWEN, daddr, dstore, dhit, halt,
        output dMemREN, dMemWEN, dMemAddr, dMemStore, stall, pending, timeout, drained
    );

    modport tb (
        output ihit, dREN, dWEN, daddr, dstore, dhit, halt,
        input  dMemREN, dMemWEN, dMemAddr, dMemStore, stall, pending, timeout, drained
    );

endinterface

// File: rtl/request_fifo.sv
// Generic circular buffer of DEPTH entries of type T. DEPTH is a power of
// two so the pointers wrap by natural overflow. Push when full and pop when
// empty are ignored.
module request_fifo
    import request_unit_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = req_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic             i_pop,
    input  T                 i_data,
    output T                 o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/request_queue_unit.sv
// Multi-entry data-memory request queue. Captures datapath requests on
// instruction-hit cycles, presents the oldest to the memory side and retires
// it on dhit. Adds a full stall, a sticky wait watchdog and halt/drain status.
module request_queue_unit
    import request_unit_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic         CLK,
    input  logic         RST,
    request_queue_if.rq  bus
);

    localparam int               CNT_W      = $clog2(DEPTH + 1);
    localparam int               WAIT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

    typedef struct packed {
        req_op_t         op;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
    } entry_t;

    entry_t            w_req;
    entry_t            w_head;
    logic              w_req_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_empty_next;
    logic              w_halt_next;
    logic [CNT_W-1:0]  w_count;
    logic [WAIT_W-1:0] w_wait_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_halt_q;
    logic              r_timeout;
    logic              r_drained;

    // Capture qualification: only on ihit, never when full or after halt.
    assign w_req_valid = bus.ihit && (bus.dREN || bus.dWEN);
    assign w_push      = w_req_valid && !w_full && !r_halt_q;
    assign w_pop       = bus.dhit && !w_empty;
    assign w_halt_next = r_halt_q || bus.halt;

    // Request record built from the datapath inputs.
    always_comb begin
        w_req      = '0;
        w_req.op   = req_op_decode(bus.dWEN);
        w_req.addr = bus.daddr;
        w_req.data = bus.dstore;
    end

    request_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_req),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy after this edge is zero only if nothing arrives and the
    // last entry (if any) leaves.
    assign w_empty_next = !w_push &&
                          ((w_count == '0) || ((w_count == CNT_W'(1)) && w_pop));

    // Head wait count: cleared by a retire or an empty queue, otherwise
    // counts up and saturates at the limit.
    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_pop || w_empty) begin
            w_wait_next = '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            w_wait_next = r_wait_cnt + 1'b1;
        end
    end

    // Watchdog, halt latch and drain flag; all sticky state clears only on RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_halt_q   <= 1'b0;
            r_drained  <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_next;
            if (TIMEOUT_EN && (w_wait_next == WAIT_MAX)) begin
                r_timeout <= 1'b1;
            end
            r_halt_q   <= w_halt_next;
            r_drained  <= w_halt_next && w_empty_next;
        end
    end

    // Head presentation; all-zero when nothing is queued.
    assign bus.dMemREN   = !w_empty && (w_head.op == REQ_READ);
    assign bus.dMemWEN   = !w_empty && (w_head.op == REQ_WRITE);
    assign bus.dMemAddr  = w_empty ? '0 : w_head.addr;
    assign bus.dMemStore = w_empty ? '0 : w_head.data;
    assign bus.stall     = w_full;
    assign bus.pending   = w_count;
    assign bus.timeout   = r_timeout;
    assign bus.drained   = r_drained;

endmodule

// File: tb/tb_request_queue_unit.sv
// Bench for request_queue_unit: a TIMEOUT=4 instance and a TIMEOUT=0 instance
// share the same stimulus. A reference model with an expected-request queue
// predicts head, occupancy, stall, timeout and drain every cycle; table rows
// also carry hand-derived occupancy/stall/timeout/drain values.
module tb_request_queue_unit;
    import request_unit_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int EW    = 1 + AW + DW;
    localparam int TO    = 4;

    typedef struct {
        logic          ihit;
        logic          ren;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          dhit;
        logic          halt;
        logic          chk;
        int            pend;
        logic          stall;
        logic          to;
        logic          drn;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ihit, dren, dwen, dhit, halt;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    int            m_cnt;
    int            m_wait;
    logic          m_halt;
    logic          m_timeout;
    vec_t          tbl_a[$];
    vec_t          tbl_b[$];

    request_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus_a ();
    request_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus_b ();

    assign bus_a.ihit = ihit;   assign bus_b.ihit = ihit;
    assign bus_a.dREN = dren;   assign bus_b.dREN = dren;
    assign bus_a.dWEN = dwen;   assign bus_b.dWEN = dwen;
    assign bus_a.daddr = daddr; assign bus_b.daddr = daddr;
    assign bus_a.dstore = dstore; assign bus_b.dstore = dstore;
    assign bus_a.dhit = dhit;   assign bus_b.dhit = dhit;
    assign bus_a.halt = halt;   assign bus_b.halt = halt;

    request_queue_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    request_queue_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(0)) dut_nt (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Global time bound
    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no end of test, expected finish before 200000");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt     = 0;
        m_wait    = 0;
        m_halt    = 1'b0;
        m_timeout = 1'b0;
    endtask

    task automatic set_idle();
        ihit = 1'b0; dren = 1'b0; dwen = 1'b0; dhit = 1'b0; halt = 1'b0;
        daddr = '0; dstore = '0;
    endtask

    // Compare every output of both instances against the model.
    task automatic check_state();
        logic [EW-1:0] h;
        logic          hv;
        hv = (exp_q.size() > 0);
        h  = hv ? exp_q[0] : '0;
        chk("pending",    64'(bus_a.pending),   64'(m_cnt));
        chk("stall",      64'(bus_a.stall),     64'(m_cnt == DEPTH));
        chk("dMemREN",    64'(bus_a.dMemREN),   64'(hv && !h[EW-1]));
        chk("dMemWEN",    64'(bus_a.dMemWEN),   64'(hv && h[EW-1]));
        chk("dMemAddr",   64'(bus_a.dMemAddr),  64'(h[AW+DW-1:DW]));
        chk("dMemStore",  64'(bus_a.dMemStore), 64'(h[DW-1:0]));
        chk("timeout",    64'(bus_a.timeout),   64'(m_timeout));
        chk("drained",    64'(bus_a.drained),   64'(m_halt && m_cnt == 0));
        chk("nt_pending", 64'(bus_b.pending),   64'(m_cnt));
        chk("nt_dMemAddr", 64'(bus_b.dMemAddr), 64'(h[AW+DW-1:DW]));
        chk("nt_timeout", 64'(bus_b.timeout),   64'(0));
    endtask

    function automatic vec_t mk(input logic i, input logic r, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic dh, input logic hl, input logic c,
                                input int p, input logic s, input logic t, input logic dr);
        vec_t v;
        v.ihit = i; v.ren = r; v.wen = w; v.addr = a; v.data = d;
        v.dhit = dh; v.halt = hl; v.chk = c; v.pend = p; v.stall = s; v.to = t; v.drn = dr;
        return v;
    endfunction

    // Driver: apply one cycle of inputs, advance the model across the edge,
    // then check outputs #1 after the edge.
    task automatic drive_cycle(input vec_t v, input string tag);
        logic acc, pop, inc;
        ihit = v.ihit; dren = v.ren; dwen = v.wen; daddr = v.addr; dstore = v.data;
        dhit = v.dhit; halt = v.halt;
        acc = v.ihit && (v.ren || v.wen) && (m_cnt < DEPTH) && !m_halt;
        pop = v.dhit && (m_cnt > 0);
        inc = (m_cnt > 0) && !v.dhit;
        @(posedge CLK);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({v.wen, v.addr, v.data});
        m_cnt  = m_cnt + int'(acc) - int'(pop);
        m_wait = inc ? m_wait + 1 : 0;
        if (m_wait >= TO) m_timeout = 1'b1;
        m_halt = m_halt | v.halt;
        #1;
        check_state();
        if (v.chk) begin
            chk($sformatf("%s_pending", tag), 64'(bus_a.pending), 64'(v.pend));
            chk($sformatf("%s_stall", tag),   64'(bus_a.stall),   64'(v.stall));
            chk($sformatf("%s_timeout", tag), 64'(bus_a.timeout), 64'(v.to));
            chk($sformatf("%s_drained", tag), 64'(bus_a.drained), 64'(v.drn));
        end
    endtask

    initial begin
        //             ihit ren wen addr      data      dhit halt chk pend stall to drn
        // single read, 3-cycle hold
        tbl_a.push_back(mk(1, 1, 0, 32'h40, 32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 0, 0));
        // fill, overflow drop, in-order drain
        tbl_a.push_back(mk(1, 0, 1, 32'h10, 32'hA,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(1, 0, 1, 32'h14, 32'hB,   0, 0, 1, 2, 1, 0, 0));
        tbl_a.push_back(mk(1, 1, 0, 32'h18, 32'hC,   0, 0, 1, 2, 1, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 0, 0));
        // push and pop together at pending=1
        tbl_a.push_back(mk(1, 0, 1, 32'h20, 32'h1,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(1, 1, 0, 32'h24, 32'h2,   1, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 0, 0));
        // both enables -> write
        tbl_a.push_back(mk(1, 1, 1, 32'h80, 32'h55,  0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 0, 0));
        // watchdog: four waiting cycles raise timeout, sticky past dhit
        tbl_a.push_back(mk(1, 1, 0, 32'h90, 32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 1, 0));
        tbl_a.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 1, 0));
        // halt: same-cycle push accepted, later pushes blocked, drain
        tbl_b.push_back(mk(1, 1, 0, 32'hA0, 32'h0,   0, 0, 1, 1, 0, 1, 0));
        tbl_b.push_back(mk(1, 1, 0, 32'hA4, 32'h0,   0, 1, 1, 2, 1, 1, 0));
        tbl_b.push_back(mk(1, 1, 0, 32'hA8, 32'h0,   0, 0, 1, 2, 1, 1, 0));
        tbl_b.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 1, 0, 1, 0));
        tbl_b.push_back(mk(1, 1, 0, 32'hAC, 32'h0,   0, 0, 1, 1, 0, 1, 0));
        tbl_b.push_back(mk(0, 0, 0, 32'h0,  32'h0,   1, 0, 1, 0, 0, 1, 1));
        tbl_b.push_back(mk(0, 0, 0, 32'h0,  32'h0,   0, 0, 1, 0, 0, 1, 1));

        // Reset
        set_idle();
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_state();
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_state();

        foreach (tbl_a[i]) drive_cycle(tbl_a[i], $sformatf("a%0d", i));

        // Nine requests back to back with a retire each cycle: pointer wrap.
        for (int i = 0; i < 9; i++) begin
            logic r;
            r = logic'(i % 2);
            drive_cycle(mk(1, r, !r, 32'h100 + 32'(4 * i), $urandom, (i > 0), 0,
                           1, 1, 0, 1, 0), $sformatf("wrap%0d", i));
        end
        drive_cycle(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0), "wrap_end");

        // Random traffic, halt held low.
        for (int i = 0; i < 60; i++) begin
            drive_cycle(mk(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                           logic'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                           $urandom, logic'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0), "rnd");
        end
        for (int k = 0; k < 4 && m_cnt > 0; k++) begin
            drive_cycle(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "flush");
        end

        foreach (tbl_b[i]) drive_cycle(tbl_b[i], $sformatf("b%0d", i));

        // Reset clears halt, then an asynchronous reset mid-request.
        set_idle();
        RST = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_state();
        drive_cycle(mk(1, 0, 1, 32'hC0, 32'h77, 0, 0, 1, 1, 0, 0, 0), "pre_rst");
        set_idle();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_state();
        chk("async_rst_dMemWEN", 64'(bus_a.dMemWEN), 64'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check_state();
        drive_cycle(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
